pc_redirect_ctrl: RTL and testbench

Sequences the pipeline after a taken jump or branch. Latches the target from the jump/branch unit, flushes the wrong-path instructions already fetched, and hands the new word address to fetch over a valid/ready handshake. Gates register-file write requests from killed stages. Sits between the execute-stage jump/branch unit and the fetch PC register.

---
 rtl/pc_redirect_ctrl.sv | 96 +++++++++
 tb/tb_pc_redirect_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// Redirect sequencer: latches a taken jump/branch target, flushes the wrong path,
// then offers the target to fetch over valid/ready. Optional macro: PC_REDIRECT_STATS_EN.
module pc_redirect_ctrl #(
    parameter int FLUSH_DEPTH = 3,
    parameter int PC_WIDTH    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                jb_enable,
    input  logic [PC_WIDTH-1:0] jb_target_pc,
    input  logic                wb_req_in,
    input  logic                pc_load_ready,
    output logic                pc_load_valid,
    output logic [PC_WIDTH-1:0] pc_load_addr,
    output logic                flush,
    output logic                wb_req_out,
    output logic                redirect_busy
`ifdef PC_REDIRECT_STATS_EN
    ,
    output logic [31:0]         redirect_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        LOAD
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_DEPTH - 1);

    state_t     state;
    logic [3:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            pc_load_valid <= 1'b0;
            pc_load_addr  <= '0;
            flush         <= 1'b0;
            redirect_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (jb_enable) begin
                        pc_load_addr  <= jb_target_pc;
                        cnt           <= CNT_INIT;
                        flush         <= 1'b1;
                        redirect_busy <= 1'b1;
                        state         <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (cnt == 4'd0) begin
                        pc_load_valid <= 1'b1;
                        state         <= LOAD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                LOAD: begin
                    // jb_enable here belongs to the wrong path, even on the handshake edge.
                    if (pc_load_ready) begin
                        pc_load_valid <= 1'b0;
                        flush         <= 1'b0;
                        redirect_busy <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    pc_load_valid <= 1'b0;
                    flush         <= 1'b0;
                    redirect_busy <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    // Combinational so the link write issued alongside jb_enable still passes.
    assign wb_req_out = wb_req_in & ~flush;

`ifdef PC_REDIRECT_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_count <= '0;
        end else if (state == IDLE && jb_enable && redirect_count != 32'hFFFF_FFFF) begin
            redirect_count <= redirect_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: FLUSH_DEPTH=3 and FLUSH_DEPTH=1 instances
// driven in parallel, compared each cycle against a cycle-timeline reference model.
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        jb_enable;
    logic [31:0] jb_target_pc;
    logic        wb_req_in;
    logic        pc_load_ready;

    logic        valid_o [2];
    logic [31:0] addr_o  [2];
    logic        flush_o [2];
    logic        wb_o    [2];
    logic        busy_o  [2];
`ifdef PC_REDIRECT_STATS_EN
    logic [31:0] count_o [2];
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.FLUSH_DEPTH(3), .PC_WIDTH(32)) u_d3 (
        .clk           (clk),
        .reset         (reset),
        .jb_enable     (jb_enable),
        .jb_target_pc  (jb_target_pc),
        .wb_req_in     (wb_req_in),
        .pc_load_ready (pc_load_ready),
        .pc_load_valid (valid_o[0]),
        .pc_load_addr  (addr_o[0]),
        .flush         (flush_o[0]),
        .wb_req_out    (wb_o[0]),
        .redirect_busy (busy_o[0])
`ifdef PC_REDIRECT_STATS_EN
        ,
        .redirect_count(count_o[0])
`endif
    );

    pc_redirect_ctrl #(.FLUSH_DEPTH(1), .PC_WIDTH(32)) u_d1 (
        .clk           (clk),
        .reset         (reset),
        .jb_enable     (jb_enable),
        .jb_target_pc  (jb_target_pc),
        .wb_req_in     (wb_req_in),
        .pc_load_ready (pc_load_ready),
        .pc_load_valid (valid_o[1]),
        .pc_load_addr  (addr_o[1]),
        .flush         (flush_o[1]),
        .wb_req_out    (wb_o[1]),
        .redirect_busy (busy_o[1])
`ifdef PC_REDIRECT_STATS_EN
        ,
        .redirect_count(count_o[1])
`endif
    );

    // Reference model: a redirect is a window in cycle numbers. It opens the cycle
    // after acceptance, offers the target from accept+depth+1 on, closes on handshake.
    int          depth [2] = '{3, 1};
    int          cycle;
    bit          m_busy [2];
    int          m_acc  [2];
    logic [31:0] m_addr [2];
    longint      m_cnt  [2];

    function automatic bit m_valid(input int i);
        return m_busy[i] && (cycle >= m_acc[i] + depth[i] + 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cycle);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0;
            m_acc[i]  = 0;
            m_addr[i] = '0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("d%0d_flush", depth[i]), 32'(flush_o[i]), 32'(m_busy[i]));
            check($sformatf("d%0d_valid", depth[i]), 32'(valid_o[i]), 32'(m_valid(i)));
            check($sformatf("d%0d_busy", depth[i]),  32'(busy_o[i]),  32'(m_busy[i]));
            check($sformatf("d%0d_addr", depth[i]),  addr_o[i],       m_addr[i]);
`ifdef PC_REDIRECT_STATS_EN
            check($sformatf("d%0d_count", depth[i]), count_o[i],
                  (m_cnt[i] > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_cnt[i]));
`endif
        end
    endtask

    // One clock cycle: drive inputs, check the combinational gate, step model and DUT.
    task automatic step(input bit jb, input logic [31:0] tgt, input bit rdy, input bit wb);
        jb_enable     = jb;
        jb_target_pc  = tgt;
        pc_load_ready = rdy;
        wb_req_in     = wb;
        #1;
        for (int i = 0; i < 2; i++)
            check($sformatf("d%0d_wb", depth[i]), 32'(wb_o[i]), 32'(wb & ~m_busy[i]));
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!m_busy[i]) begin
                if (jb) begin
                    m_busy[i] = 1'b1;
                    m_acc[i]  = cycle;
                    m_addr[i] = tgt;
                    m_cnt[i]++;
                end
            end else if (m_valid(i) && rdy) begin
                m_busy[i] = 1'b0;
            end
        end
        cycle++;
        #1;
        check_regs();
    endtask

    task automatic idle(input int n, input bit rdy, input bit wb);
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, rdy, wb);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        jb_enable = 1'b0;
        #2;
        model_reset();
        check_regs();
        @(posedge clk);
        cycle++;
        #1;
        reset = 1'b0;
        #1;
        check_regs();
    endtask

    initial begin
        reset = 1'b1;
        jb_enable = 1'b0;
        jb_target_pc = '0;
        wb_req_in = 1'b0;
        pc_load_ready = 1'b0;
        cycle = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_regs();

        // Basic redirect with ready tied high and a continuous writeback request.
        step(1'b1, 32'h0000_0040, 1'b1, 1'b1);
        idle(3, 1'b1, 1'b1);
        check("tp1_load_valid", 32'(valid_o[0]), 32'd1);
        check("tp1_load_addr", addr_o[0], 32'h40);
        idle(2, 1'b1, 1'b1);
        check("tp1_idle", 32'(busy_o[0]), 32'd0);

        // Fetch stalls five cycles in LOAD; a wrong-path jb during FLUSH is ignored.
        step(1'b1, 32'h0000_0040, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0080, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);
        idle(5, 1'b0, 1'b0);
        check("tp2_held_addr", addr_o[0], 32'h40);
        // Handshake edge with a coincident jb, then back-to-back redirect.
        step(1'b1, 32'h0000_0099, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0123, 1'b1, 1'b1);
        idle(6, 1'b1, 1'b1);

        // Reset during LOAD, then a fresh sequence.
        step(1'b1, 32'h0000_0777, 1'b0, 1'b0);
        idle(4, 1'b0, 1'b0);
        check("tp5_in_load", 32'(valid_o[0]), 32'd1);
        pulse_reset();
        step(1'b1, 32'h0000_0010, 1'b1, 1'b0);
        idle(5, 1'b1, 1'b0);
        check("tp5_fresh_addr", addr_o[0], 32'h10);

        // Randomized traffic, with an occasional reset.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else step($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
